mem_responder: RTL and testbench

- Memory-side responder for the multicycle core's data/instruction port.
- Accepts one request at a time on a valid/ready bus carrying a byte address, the RV32 funct3 size code and write data.
- Drives a word-wide synchronous SRAM with a configurable read latency.
- Returns loads lane-aligned and sign- or zero-extended; flags misaligned, illegal-size and out-of-range accesses.

---
 rtl/mem_responder.sv | 160 ++++++++++++++++
 tb/tb_mem_responder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: valid/ready request bus in front of a word-wide
// synchronous SRAM, returning lane-aligned, extended load data or an error flag.
module mem_responder #(
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 1,
  localparam int AW         = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [31:0]   req_addr,
  input  logic [2:0]    req_size,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          sram_en,
  output logic          sram_we,
  output logic [3:0]    sram_be,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata
);

  // state  | meaning
  // IDLE   | ready for a request
  // ACCESS | one-cycle SRAM strobe (read or write)
  // WAIT   | read latency countdown, captures read data on terminal count
  // RESP   | response held until rsp_ready
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

  localparam logic [31:0] DEPTH_U = DEPTH_WORDS;
  localparam logic [1:0]  LAT_M1  = 2'(LATENCY - 1);

  state_t        r_state;
  state_t        w_next;
  logic          r_we;
  logic [AW+1:0] r_addr;
  logic [2:0]    r_size;
  logic [31:0]   r_wdata;
  logic          r_err;
  logic [1:0]    r_cnt;
  logic [31:0]   r_hold;

  logic          w_accept;
  logic          w_req_err;
  logic [3:0]    w_be_st;
  logic [31:0]   w_wdata_st;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load;

  always_comb begin
    w_req_err = 1'b0;
    if (req_size == 3'b011 || req_size == 3'b110 || req_size == 3'b111)  w_req_err = 1'b1;
    if (req_we && req_size[2])                                           w_req_err = 1'b1;
    if (req_size[1:0] == 2'b01 && req_addr[0])                           w_req_err = 1'b1;
    if (req_size == 3'b010 && req_addr[1:0] != 2'b00)                    w_req_err = 1'b1;
    if ({2'b00, req_addr[31:2]} >= DEPTH_U)                              w_req_err = 1'b1;
  end

  assign w_accept = req_valid && (r_state == S_IDLE);

  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_be    = 4'b0000;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (w_accept) w_next = w_req_err ? S_RESP : S_ACCESS;
      end
      S_ACCESS: begin
        sram_en = 1'b1;
        sram_we = r_we;
        sram_be = r_we ? w_be_st : 4'b1111;
        w_next  = r_we ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == 2'd0) w_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_size  <= 3'b000;
      r_wdata <= 32'h0;
      r_err   <= 1'b0;
      r_cnt   <= 2'd0;
      r_hold  <= 32'h0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr[AW+1:0];
        r_size  <= req_size;
        r_wdata <= req_wdata;
        r_err   <= w_req_err;
      end
      if (r_state == S_ACCESS) r_cnt <= LAT_M1;
      if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 2'd1;
        if (r_cnt == 2'd0) r_hold <= sram_rdata;
      end
    end
  end

  always_comb begin
    case (r_size[1:0])
      2'b00:   w_be_st = 4'b0001 << r_addr[1:0];
      2'b01:   w_be_st = r_addr[1] ? 4'b1100 : 4'b0011;
      default: w_be_st = 4'b1111;
    endcase
    case (r_size[1:0])
      2'b00:   w_wdata_st = {4{r_wdata[7:0]}};
      2'b01:   w_wdata_st = {2{r_wdata[15:0]}};
      default: w_wdata_st = r_wdata;
    endcase
  end

  assign sram_addr  = r_addr[AW+1:2];
  assign sram_wdata = w_wdata_st;

  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_byte = r_hold[7:0];
      2'd1:    w_byte = r_hold[15:8];
      2'd2:    w_byte = r_hold[23:16];
      default: w_byte = r_hold[31:24];
    endcase
    w_half = r_addr[1] ? r_hold[31:16] : r_hold[15:0];
    case (r_size)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'h0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'h0, w_half};
      default: w_load = r_hold;
    endcase
  end

  // Data and error are gated by state so an async reset clears them without a clock.
  assign rsp_rdata = (r_state == S_RESP && !r_err && !r_we) ? w_load : 32'h0;
  assign rsp_err   = (r_state == S_RESP) && r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance at read latency 1, one at latency 3,
// each backed by a behavioural SRAM; sel chooses which instance the request bus drives.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        mem_clr;
  logic        req_valid, req_we, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_size;

  logic        req_ready1, rsp_valid1, rsp_err1, sram_en1, sram_we1;
  logic [31:0] rsp_rdata1, sram_wdata1, sram_rdata1;
  logic [3:0]  sram_be1;
  logic [11:0] sram_addr1;
  logic        req_ready3, rsp_valid3, rsp_err3, sram_en3, sram_we3;
  logic [31:0] rsp_rdata3, sram_wdata3, sram_rdata3;
  logic [3:0]  sram_be3;
  logic [11:0] sram_addr3;

  logic        req_ready, rsp_valid, rsp_err, sram_en, sram_we;
  logic [31:0] rsp_rdata, sram_wdata;
  logic [3:0]  sram_be;
  logic [11:0] sram_addr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(4096), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid && !sel), .req_ready(req_ready1), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready && !sel), .rsp_rdata(rsp_rdata1),
    .rsp_err(rsp_err1), .sram_en(sram_en1), .sram_we(sram_we1), .sram_be(sram_be1),
    .sram_addr(sram_addr1), .sram_wdata(sram_wdata1), .sram_rdata(sram_rdata1)
  );

  mem_responder #(.DEPTH_WORDS(4096), .LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid && sel), .req_ready(req_ready3), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready && sel), .rsp_rdata(rsp_rdata3),
    .rsp_err(rsp_err3), .sram_en(sram_en3), .sram_we(sram_we3), .sram_be(sram_be3),
    .sram_addr(sram_addr3), .sram_wdata(sram_wdata3), .sram_rdata(sram_rdata3)
  );

  assign req_ready  = sel ? req_ready3  : req_ready1;
  assign rsp_valid  = sel ? rsp_valid3  : rsp_valid1;
  assign rsp_err    = sel ? rsp_err3    : rsp_err1;
  assign rsp_rdata  = sel ? rsp_rdata3  : rsp_rdata1;
  assign sram_en    = sel ? sram_en3    : sram_en1;
  assign sram_we    = sel ? sram_we3    : sram_we1;
  assign sram_be    = sel ? sram_be3    : sram_be1;
  assign sram_addr  = sel ? sram_addr3  : sram_addr1;
  assign sram_wdata = sel ? sram_wdata3 : sram_wdata1;

  // Behavioural SRAMs: byte-enabled writes, read data delayed by the instance's latency.
  logic [31:0] mem1 [4096];
  logic [31:0] mem3 [4096];
  logic [31:0] pipe1;
  logic [31:0] pipe3 [3];
  assign sram_rdata1 = pipe1;
  assign sram_rdata3 = pipe3[2];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) mem1[i] <= 32'h0;
    end else if (sram_en1 && sram_we1) begin
      for (int b = 0; b < 4; b++)
        if (sram_be1[b]) mem1[sram_addr1][8*b +: 8] <= sram_wdata1[8*b +: 8];
    end else if (sram_en1) begin
      pipe1 <= mem1[sram_addr1];
    end
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) mem3[i] <= 32'h0;
    end else if (sram_en3 && sram_we3) begin
      for (int b = 0; b < 4; b++)
        if (sram_be3[b]) mem3[sram_addr3][8*b +: 8] <= sram_wdata3[8*b +: 8];
    end else if (sram_en3) begin
      pipe3[0] <= mem3[sram_addr3];
    end
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [31:0] got_rdata, acc_wd;
  logic        got_err, en_seen, acc_en, acc_we;
  logic [3:0]  acc_be;
  logic [11:0] acc_addr;
  int          got_lat;

  task automatic txn(input logic we, input logic [31:0] addr, input logic [2:0] size,
                     input logic [31:0] wdata);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    acc_en = sram_en; acc_we = sram_we; acc_be = sram_be; acc_wd = sram_wdata; acc_addr = sram_addr;
    en_seen = sram_en;
    got_lat = 0;
    while (!rsp_valid && got_lat < 20) begin
      @(posedge clk); #1;
      got_lat++;
      en_seen = en_seen | sram_en;
    end
    got_rdata = rsp_rdata;
    got_err   = rsp_err;
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    check("rsp_drop", {31'b0, rsp_valid}, 32'h0);
  endtask

  task automatic run(input string tag, input logic we, input logic [31:0] addr,
                     input logic [2:0] size, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    txn(we, addr, size, wdata);
    check({tag, ".rdata"}, got_rdata, exp_rdata);
    check({tag, ".err"}, {31'b0, got_err}, {31'b0, exp_err});
    check({tag, ".lat"}, got_lat, exp_lat);
    if (exp_err) check({tag, ".no_en"}, {31'b0, en_seen}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0; mem_clr = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_size = 3'b010; req_wdata = 32'h0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.ready", {31'b0, req_ready}, 32'h1);
    check("rst.rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("rst.sram_en", {31'b0, sram_en}, 32'h0);
    check("rst.rdata", rsp_rdata, 32'h0);
    mem_clr = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("rel.ready", {31'b0, req_ready}, 32'h1);
    check("rel.rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("rel.sram_en", {31'b0, sram_en}, 32'h0);

    // Latency-1 instance: stores (1 edge to RESP), loads (2 edges), errors (0 edges).
    run("sw", 1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0, 1'b0, 1);
    check("sw.en", {31'b0, acc_en}, 32'h1);
    check("sw.we", {31'b0, acc_we}, 32'h1);
    check("sw.be", {28'b0, acc_be}, 32'hF);
    check("sw.addr", {20'b0, acc_addr}, 32'h4);
    check("sw.wdata", acc_wd, 32'hDEADBEEF);
    run("lb",  1'b0, 32'h13, 3'b000, 32'h0, 32'hFFFFFFDE, 1'b0, 2);
    check("lb.be", {28'b0, acc_be}, 32'hF);
    check("lb.we", {31'b0, acc_we}, 32'h0);
    run("lbu", 1'b0, 32'h13, 3'b100, 32'h0, 32'h000000DE, 1'b0, 2);
    run("lh",  1'b0, 32'h10, 3'b001, 32'h0, 32'hFFFFBEEF, 1'b0, 2);
    run("lhu", 1'b0, 32'h12, 3'b101, 32'h0, 32'h0000DEAD, 1'b0, 2);
    run("sb",  1'b1, 32'h11, 3'b000, 32'h12345655, 32'h0, 1'b0, 1);
    check("sb.be", {28'b0, acc_be}, 32'h2);
    check("sb.wdata", acc_wd, 32'h55555555);
    run("lw1", 1'b0, 32'h10, 3'b010, 32'h0, 32'hDEAD55EF, 1'b0, 2);
    run("lb1", 1'b0, 32'h11, 3'b000, 32'h0, 32'h00000055, 1'b0, 2);
    run("sh",  1'b1, 32'h12, 3'b001, 32'h0000CAFE, 32'h0, 1'b0, 1);
    check("sh.be", {28'b0, acc_be}, 32'hC);
    check("sh.wdata", acc_wd, 32'hCAFECAFE);
    run("lw2", 1'b0, 32'h10, 3'b010, 32'h0, 32'hCAFE55EF, 1'b0, 2);
    run("e_lw_mis", 1'b0, 32'h12,   3'b010, 32'h0, 32'h0, 1'b1, 0);
    run("e_lh_mis", 1'b0, 32'h11,   3'b001, 32'h0, 32'h0, 1'b1, 0);
    run("e_sz011",  1'b0, 32'h0,    3'b011, 32'h0, 32'h0, 1'b1, 0);
    run("e_sbu",    1'b1, 32'h0,    3'b100, 32'h0, 32'h0, 1'b1, 0);
    run("e_range",  1'b0, 32'h4000, 3'b010, 32'h0, 32'h0, 1'b1, 0);

    // Async reset while a store is in ACCESS: strobes drop at once, no write lands.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_size = 3'b010; req_wdata = 32'h11111111;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("racc.en_before", {31'b0, sram_en}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("racc.en", {31'b0, sram_en}, 32'h0);
    check("racc.we", {31'b0, sram_we}, 32'h0);
    check("racc.be", {28'b0, sram_be}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    run("racc.lw", 1'b0, 32'h20, 3'b010, 32'h0, 32'h0, 1'b0, 2);

    // Latency-3 instance.
    @(negedge clk); sel = 1'b1;
    run("sw3", 1'b1, 32'h0, 3'b010, 32'h0BADF00D, 32'h0, 1'b0, 1);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0; req_size = 3'b010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    got_lat = 0;
    while (!rsp_valid && got_lat < 20) begin
      @(posedge clk); #1;
      got_lat++;
    end
    check("lw3.lat", got_lat, 4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = (i == 2); req_we = 1'b0; req_addr = 32'h4; req_size = 3'b010;
      check("hold.valid", {31'b0, rsp_valid}, 32'h1);
      check("hold.rdata", rsp_rdata, 32'h0BADF00D);
      check("hold.ready", {31'b0, req_ready}, 32'h0);
    end
    @(negedge clk); req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    check("hs.valid", {31'b0, rsp_valid}, 32'h0);
    check("hs.ready", {31'b0, req_ready}, 32'h1);
    repeat (3) @(posedge clk);
    #1;
    check("hs.no_accept", {31'b0, req_ready}, 32'h1);

    // Async reset while a load sits in WAIT.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0; req_size = 3'b010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rwait.valid", {31'b0, rsp_valid}, 32'h0);
    check("rwait.ready", {31'b0, req_ready}, 32'h1);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rwait.quiet", {31'b0, rsp_valid}, 32'h0);
    run("rwait.lw", 1'b0, 32'h0, 3'b010, 32'h0, 32'h0BADF00D, 1'b0, 4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
